// File: rtl/vls_sp_seq_pkg.sv
// Shared types for the scratchpad tile sequencer: operation encoding, FSM states
// and a sizing helper for the outstanding-read counter.
package vls_sp_seq_pkg;

  typedef enum logic {
    LOAD  = 1'b0,
    STORE = 1'b1
  } vls_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  // Counter width able to hold the value max_out itself.
  function automatic int out_cnt_w(input int max_out);
    return $clog2(max_out) + 1;
  endfunction

endpackage

// File: rtl/vls_sp_seq_addr_gen.sv
// Tile walker: row/column counters, walk order, word address and last-element flag.
// Counters move one element per step; load restarts the walk at element (0,0).
module vls_sp_seq_addr_gen #(
  parameter int ADDR_W     = 16,
  parameter int DIM_W      = 6,
  parameter int ROW_STRIDE = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              load,
  input  logic [ADDR_W-1:0] base,
  input  logic [DIM_W-1:0]  num_rows,
  input  logic [DIM_W-1:0]  num_cols,
  input  logic              row_col,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [DIM_W-1:0] DIM_ONE = DIM_W'(1);

  logic [ADDR_W-1:0] base_q, base_d;
  logic [DIM_W-1:0]  rows_q, rows_d;
  logic [DIM_W-1:0]  cols_q, cols_d;
  logic              rc_q, rc_d;
  logic [DIM_W-1:0]  r_q, r_d;
  logic [DIM_W-1:0]  c_q, c_d;
  logic              r_end_s;
  logic              c_end_s;

  assign r_end_s = (r_q == rows_q - DIM_ONE);
  assign c_end_s = (c_q == cols_q - DIM_ONE);

  // Next-state for the walk counters and latched tile geometry.
  always_comb begin
    base_d = base_q;
    rows_d = rows_q;
    cols_d = cols_q;
    rc_d   = rc_q;
    r_d    = r_q;
    c_d    = c_q;
    if (load) begin
      base_d = base;
      rows_d = num_rows;
      cols_d = num_cols;
      rc_d   = row_col;
      r_d    = {DIM_W{1'b0}};
      c_d    = {DIM_W{1'b0}};
    end else if (step) begin
      if (!rc_q) begin
        if (c_end_s) begin
          c_d = {DIM_W{1'b0}};
          r_d = r_q + DIM_ONE;
        end else begin
          c_d = c_q + DIM_ONE;
        end
      end else begin
        if (r_end_s) begin
          r_d = {DIM_W{1'b0}};
          c_d = c_q + DIM_ONE;
        end else begin
          r_d = r_q + DIM_ONE;
        end
      end
    end else begin
      r_d = r_q;
    end
  end

  // Walk state registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      base_q <= {ADDR_W{1'b0}};
      rows_q <= {DIM_W{1'b0}};
      cols_q <= {DIM_W{1'b0}};
      rc_q   <= 1'b0;
      r_q    <= {DIM_W{1'b0}};
      c_q    <= {DIM_W{1'b0}};
    end else begin
      base_q <= base_d;
      rows_q <= rows_d;
      cols_q <= cols_d;
      rc_q   <= rc_d;
      r_q    <= r_d;
      c_q    <= c_d;
    end
  end

  // Address wraps modulo 2^ADDR_W by truncation.
  assign addr = base_q + (ADDR_W'(r_q) * ADDR_W'(ROW_STRIDE)) + ADDR_W'(c_q);
  assign last = r_end_s && c_end_s;

endmodule

// File: rtl/vls_sp_seq.sv
// Expands one tile load/store request into one scratchpad word access per cycle,
// streams load returns in order and pulses dhit when the tile is complete.
module vls_sp_seq
  import vls_sp_seq_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int DIM_W      = 6,
  parameter int ROW_STRIDE = 32,
  parameter int MAX_OUT    = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_op,
  input  logic [ADDR_W-1:0] req_base,
  input  logic              req_row_col,
  input  logic [DIM_W-1:0]  req_num_rows,
  input  logic [DIM_W-1:0]  req_num_cols,
  input  logic              req_id,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [DATA_W-1:0] st_data,
  output logic              ld_valid,
  output logic [DATA_W-1:0] ld_data,
  output logic              ld_last,
  output logic              dhit,
  output logic              dhit_id,
  output logic              busy,
  output logic              sp_req_valid,
  input  logic              sp_req_ready,
  output logic              sp_req_we,
  output logic [ADDR_W-1:0] sp_req_addr,
  output logic [DATA_W-1:0] sp_req_wdata,
  input  logic              sp_rvalid,
  input  logic [DATA_W-1:0] sp_rdata
);

  localparam int OUT_W = out_cnt_w(MAX_OUT);
  localparam int CNT_W = 2 * DIM_W;

  seq_state_t        state_q, state_d;
  vls_op_t           op_q, op_d;
  logic              id_q, id_d;
  logic [CNT_W-1:0]  total_q, total_d;
  logic [CNT_W-1:0]  ret_q, ret_d;
  logic [OUT_W-1:0]  out_q, out_d;

  logic              accept_req_s;
  logic              issue_s;
  logic              acc_s;
  logic              ret_s;
  logic              gen_last_s;
  logic [ADDR_W-1:0] gen_addr_s;

  assign req_ready    = (state_q == IDLE);
  assign accept_req_s = req_valid && req_ready;
  assign issue_s      = (state_q == ISSUE);
  assign busy         = (state_q != IDLE);
  assign dhit         = (state_q == DONE);
  assign dhit_id      = dhit ? id_q : 1'b0;

  vls_sp_seq_addr_gen #(
    .ADDR_W     (ADDR_W),
    .DIM_W      (DIM_W),
    .ROW_STRIDE (ROW_STRIDE)
  ) u_addr_gen (
    .CLK      (CLK),
    .RST      (RST),
    .load     (accept_req_s),
    .base     (req_base),
    .num_rows (req_num_rows),
    .num_cols (req_num_cols),
    .row_col  (req_row_col),
    .step     (acc_s),
    .addr     (gen_addr_s),
    .last     (gen_last_s)
  );

  // Scratchpad request and store-stream handshake, only live in ISSUE.
  always_comb begin
    sp_req_valid = 1'b0;
    sp_req_we    = 1'b0;
    sp_req_wdata = {DATA_W{1'b0}};
    st_ready     = 1'b0;
    if (issue_s) begin
      if (op_q == LOAD) begin
        sp_req_valid = (out_q < OUT_W'(MAX_OUT));
      end else begin
        sp_req_valid = st_valid;
        sp_req_we    = 1'b1;
        sp_req_wdata = st_data;
        st_ready     = sp_req_ready;
      end
    end else begin
      st_ready = 1'b0;
    end
  end

  assign sp_req_addr = issue_s ? gen_addr_s : {ADDR_W{1'b0}};
  assign acc_s       = sp_req_valid && sp_req_ready;

  // Returns outside a live load tile (e.g. after a mid-tile reset) are dropped.
  assign ret_s    = sp_rvalid && (op_q == LOAD) && ((state_q == ISSUE) || (state_q == DRAIN));
  assign ld_valid = ret_s;
  assign ld_data  = ret_s ? sp_rdata : {DATA_W{1'b0}};
  assign ld_last  = ret_s && ((ret_q + CNT_W'(1)) == total_q);

  // Sequencer next state, outstanding-read tracking and return counting.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    id_d    = id_q;
    total_d = total_q;
    ret_d   = ret_s ? (ret_q + CNT_W'(1)) : ret_q;
    case ({acc_s && (op_q == LOAD), ret_s})
      2'b10:   out_d = out_q + OUT_W'(1);
      2'b01:   out_d = out_q - OUT_W'(1);
      default: out_d = out_q;
    endcase
    case (state_q)
      IDLE: begin
        if (accept_req_s) begin
          op_d    = vls_op_t'(req_op);
          id_d    = req_id;
          total_d = CNT_W'(req_num_rows) * CNT_W'(req_num_cols);
          ret_d   = {CNT_W{1'b0}};
          out_d   = {OUT_W{1'b0}};
          if ((req_num_rows == {DIM_W{1'b0}}) || (req_num_cols == {DIM_W{1'b0}})) begin
            state_d = DONE;
          end else begin
            state_d = ISSUE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (acc_s && gen_last_s) begin
          if ((op_q == LOAD) && (out_d != {OUT_W{1'b0}})) begin
            state_d = DRAIN;
          end else begin
            state_d = DONE;
          end
        end else begin
          state_d = ISSUE;
        end
      end
      DRAIN: begin
        if (out_d == {OUT_W{1'b0}}) begin
          state_d = DONE;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sequencer registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      op_q    <= LOAD;
      id_q    <= 1'b0;
      total_q <= {CNT_W{1'b0}};
      ret_q   <= {CNT_W{1'b0}};
      out_q   <= {OUT_W{1'b0}};
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      id_q    <= id_d;
      total_q <= total_d;
      ret_q   <= ret_d;
      out_q   <= out_d;
    end
  end

endmodule

// File: tb/tb_vls_sp_seq.sv
// Directed bench for vls_sp_seq: table of tile requests against a scratchpad model
// with configurable read latency and stalls, plus a reset-during-drain sequence.
module tb_vls_sp_seq;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_valid, req_ready, req_op, req_row_col, req_id;
  logic [15:0] req_base;
  logic [5:0]  req_num_rows, req_num_cols;
  logic        st_valid, st_ready;
  logic [15:0] st_data;
  logic        ld_valid, ld_last, dhit, dhit_id, busy;
  logic [15:0] ld_data;
  logic        sp_req_valid, sp_req_ready, sp_req_we, sp_rvalid;
  logic [15:0] sp_req_addr, sp_req_wdata, sp_rdata;

  always #5 CLK = ~CLK;

  vls_sp_seq #(.ADDR_W(16), .DATA_W(16), .DIM_W(6), .ROW_STRIDE(32), .MAX_OUT(4)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_base(req_base),
    .req_row_col(req_row_col), .req_num_rows(req_num_rows), .req_num_cols(req_num_cols),
    .req_id(req_id), .st_valid(st_valid), .st_ready(st_ready), .st_data(st_data),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .dhit(dhit), .dhit_id(dhit_id),
    .busy(busy), .sp_req_valid(sp_req_valid), .sp_req_ready(sp_req_ready), .sp_req_we(sp_req_we),
    .sp_req_addr(sp_req_addr), .sp_req_wdata(sp_req_wdata), .sp_rvalid(sp_rvalid), .sp_rdata(sp_rdata)
  );

  typedef struct {
    logic        op;
    logic [15:0] base;
    logic [5:0]  rows;
    logic [5:0]  cols;
    logic        rc;
    logic        id;
    int          lat;
    logic        tog;
    int          stall_at;
    logic [15:0] exp_first;
    logic [15:0] exp_last;
    int          exp_n;
  } vec_t;

  typedef struct {
    int          due;
    logic [15:0] addr;
  } pend_t;

  vec_t        vecs[8];
  pend_t       pend[$];
  logic [15:0] acc_addr[$];
  logic        acc_we[$];
  logic [15:0] acc_wd[$];
  logic [15:0] ld_q[$];
  int tests = 0, fails = 0;
  int cyc = 0, lat_cur = 1, out_cnt = 0, out_max = 0, hold_err = 0, st_idx = 0, vld_seen = 0;
  int last_cnt = 0, last_pos = 0, dhit_cnt = 0, acc_cyc = 0, dhit_cyc = 0;
  int stall_at = -1, stall_left = 0;
  logic dhit_id_seen = 1'b0, tog_st = 1'b0, st_en = 1'b0, stall_done = 1'b0, prev_stalled = 1'b0;
  logic [15:0] prev_addr = 16'h0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference walk: element k -> (r,c) by division, independent of counters.
  function automatic logic [15:0] exp_addr(input vec_t v, input int k);
    int r, c;
    if (v.rc == 1'b0) begin
      r = k / int'(v.cols);
      c = k % int'(v.cols);
    end else begin
      c = k / int'(v.rows);
      r = k % int'(v.rows);
    end
    return 16'(int'(v.base) + r * 32 + c);
  endfunction

  // Observe DUT outputs mid-cycle.
  always @(negedge CLK) begin
    if (sp_req_valid) vld_seen++;
    if (sp_req_valid && !sp_req_ready) begin
      if (prev_stalled && (sp_req_addr !== prev_addr)) hold_err++;
      prev_addr    = sp_req_addr;
      prev_stalled = 1'b1;
    end else begin
      prev_stalled = 1'b0;
    end
    if (sp_req_valid && sp_req_ready) begin
      acc_addr.push_back(sp_req_addr);
      acc_we.push_back(sp_req_we);
      acc_wd.push_back(sp_req_wdata);
      if (sp_req_we && !st_valid) hold_err++;
      if (!sp_req_we) begin
        pend.push_back('{due: cyc + lat_cur, addr: sp_req_addr});
        out_cnt++;
      end
    end
    if (sp_rvalid) out_cnt--;
    if (out_cnt > out_max) out_max = out_cnt;
    if (st_valid && st_ready) st_idx++;
    if (ld_valid) begin
      ld_q.push_back(ld_data);
      if (ld_last) begin
        last_cnt++;
        last_pos = ld_q.size();
      end
    end
    if (dhit) begin
      dhit_cnt++;
      dhit_id_seen = dhit_id;
      dhit_cyc     = cyc;
    end
    if (req_valid && req_ready) acc_cyc = cyc;
  end

  // Scratchpad model, stall injection and store-data source.
  initial begin
    sp_rvalid = 1'b0; sp_rdata = 16'h0; sp_req_ready = 1'b1;
    st_valid = 1'b0; st_data = 16'hC000;
    forever begin
      @(posedge CLK);
      cyc++;
      #1;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        sp_rvalid = 1'b1;
        sp_rdata  = pend[0].addr ^ 16'hA5A5;
        void'(pend.pop_front());
      end else begin
        sp_rvalid = 1'b0;
        sp_rdata  = 16'h0;
      end
      if (stall_left > 0) begin
        sp_req_ready = 1'b0;
        stall_left--;
      end else if (!stall_done && stall_at >= 1 && acc_addr.size() == stall_at) begin
        stall_done   = 1'b1;
        stall_left   = 4;
        sp_req_ready = 1'b0;
      end else begin
        sp_req_ready = 1'b1;
      end
      st_valid = tog_st ? ~st_valid : st_en;
      st_data  = 16'(32'hC000 + st_idx);
    end
  end

  task automatic clear_logs(input vec_t v);
    acc_addr.delete(); acc_we.delete(); acc_wd.delete(); ld_q.delete();
    out_cnt = 0; out_max = 0; hold_err = 0; st_idx = 0; vld_seen = 0;
    last_cnt = 0; last_pos = 0; dhit_cnt = 0;
    lat_cur = v.lat; tog_st = v.tog; st_en = v.op;
    stall_at = v.stall_at; stall_done = 1'b0; stall_left = 0;
  endtask

  task automatic send_req(input vec_t v);
    bit got;
    got = 1'b0;
    @(posedge CLK); #1;
    req_valid = 1'b1; req_op = v.op; req_base = v.base; req_row_col = v.rc;
    req_num_rows = v.rows; req_num_cols = v.cols; req_id = v.id;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge CLK);
      if (req_ready) got = 1'b1;
    end
    check("req_accept", int'(got), 1);
    @(posedge CLK); #1;
    req_valid = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    clear_logs(v);
    send_req(v);
    for (int i = 0; i < 600 && dhit_cnt == 0; i++) @(negedge CLK);
    repeat (4) @(negedge CLK);
    tog_st = 1'b0; st_en = 1'b0;
    check($sformatf("v%0d_n_access", idx), acc_addr.size(), v.exp_n);
    if (v.exp_n > 0 && acc_addr.size() > 0) begin
      check($sformatf("v%0d_first_addr", idx), int'(acc_addr[0]), int'(v.exp_first));
      check($sformatf("v%0d_last_addr", idx), int'(acc_addr[acc_addr.size()-1]), int'(v.exp_last));
    end
    for (int k = 0; k < acc_addr.size() && k < v.exp_n; k++) begin
      check($sformatf("v%0d_addr%0d", idx, k), int'(acc_addr[k]), int'(exp_addr(v, k)));
      check($sformatf("v%0d_we%0d", idx, k), int'(acc_we[k]), int'(v.op));
      if (v.op) check($sformatf("v%0d_wdata%0d", idx, k), int'(acc_wd[k]), 32'hC000 + k);
    end
    check($sformatf("v%0d_ld_count", idx), ld_q.size(), v.op ? 0 : v.exp_n);
    for (int k = 0; k < ld_q.size() && k < v.exp_n; k++)
      check($sformatf("v%0d_ld_data%0d", idx, k), int'(ld_q[k]), int'(exp_addr(v, k) ^ 16'hA5A5));
    check($sformatf("v%0d_ld_last_cnt", idx), last_cnt, (!v.op && v.exp_n > 0) ? 1 : 0);
    if (last_cnt > 0) check($sformatf("v%0d_ld_last_pos", idx), last_pos, v.exp_n);
    check($sformatf("v%0d_dhit_cnt", idx), dhit_cnt, 1);
    check($sformatf("v%0d_dhit_id", idx), int'(dhit_id_seen), int'(v.id));
    check($sformatf("v%0d_hold_err", idx), hold_err, 0);
    check($sformatf("v%0d_out_le_max", idx), int'(out_max <= 4), 1);
    if (v.lat >= 10) check($sformatf("v%0d_out_reach_max", idx), out_max, 4);
    if (v.exp_n == 0) begin
      check($sformatf("v%0d_no_sp_valid", idx), vld_seen, 0);
      check($sformatf("v%0d_dhit_lat", idx), int'((dhit_cyc - acc_cyc) >= 1 && (dhit_cyc - acc_cyc) <= 2), 1);
    end
  endtask

  initial begin
    vec_t rv;
    bit   got;
    vecs[0] = '{op:1'b0, base:16'h0010, rows:6'd2, cols:6'd3, rc:1'b0, id:1'b0, lat:1,  tog:1'b0, stall_at:-1, exp_first:16'h0010, exp_last:16'h0032, exp_n:6};
    vecs[1] = '{op:1'b1, base:16'h0000, rows:6'd3, cols:6'd2, rc:1'b1, id:1'b1, lat:1,  tog:1'b1, stall_at:-1, exp_first:16'h0000, exp_last:16'h0041, exp_n:6};
    vecs[2] = '{op:1'b0, base:16'h0100, rows:6'd4, cols:6'd4, rc:1'b0, id:1'b1, lat:10, tog:1'b0, stall_at:-1, exp_first:16'h0100, exp_last:16'h0163, exp_n:16};
    vecs[3] = '{op:1'b0, base:16'hFFFF, rows:6'd1, cols:6'd2, rc:1'b0, id:1'b0, lat:2,  tog:1'b0, stall_at:-1, exp_first:16'hFFFF, exp_last:16'h0000, exp_n:2};
    vecs[4] = '{op:1'b0, base:16'h0020, rows:6'd0, cols:6'd5, rc:1'b0, id:1'b1, lat:1,  tog:1'b0, stall_at:-1, exp_first:16'h0000, exp_last:16'h0000, exp_n:0};
    vecs[5] = '{op:1'b0, base:16'h0200, rows:6'd2, cols:6'd4, rc:1'b1, id:1'b0, lat:3,  tog:1'b0, stall_at:3,  exp_first:16'h0200, exp_last:16'h0223, exp_n:8};
    vecs[6] = '{op:1'b1, base:16'h0040, rows:6'd2, cols:6'd2, rc:1'b0, id:1'b1, lat:1,  tog:1'b0, stall_at:2,  exp_first:16'h0040, exp_last:16'h0061, exp_n:4};
    vecs[7] = '{op:1'b0, base:16'h0300, rows:6'd3, cols:6'd1, rc:1'b1, id:1'b1, lat:1,  tog:1'b0, stall_at:-1, exp_first:16'h0300, exp_last:16'h0340, exp_n:3};

    RST = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_base = 16'h0; req_row_col = 1'b0;
    req_num_rows = 6'd0; req_num_cols = 6'd0; req_id = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("rst_busy", int'(busy), 0);
    check("rst_dhit", int'(dhit), 0);
    check("rst_sp_valid", int'(sp_req_valid), 0);
    check("rst_st_ready", int'(st_ready), 0);
    check("rst_ld_valid", int'(ld_valid), 0);
    check("rst_req_ready", int'(req_ready), 1);

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Reset while draining a LOAD tile: tile dropped, late returns ignored.
    rv = '{op:1'b0, base:16'h0080, rows:6'd2, cols:6'd2, rc:1'b0, id:1'b1, lat:10, tog:1'b0, stall_at:-1, exp_first:16'h0080, exp_last:16'h00A1, exp_n:4};
    clear_logs(rv);
    send_req(rv);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge CLK);
      if (acc_addr.size() == 4) got = 1'b1;
    end
    check("drain_issued", int'(got), 1);
    @(negedge CLK);
    check("drain_busy", int'(busy), 1);
    @(posedge CLK); #1 RST = 1'b1;
    @(posedge CLK); #1 RST = 1'b0;
    for (int i = 0; i < 40 && pend.size() > 0; i++) @(negedge CLK);
    repeat (3) @(negedge CLK);
    check("drain_rst_no_dhit", dhit_cnt, 0);
    check("drain_rst_no_ld", ld_q.size(), 0);
    check("drain_rst_idle", int'(busy), 0);
    run_vec(8, vecs[2]);
    run_vec(9, vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
